// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths, opcode encoding and exec_unit FSM states
package cpu_pkg;

  localparam int DATA_W = 19;
  localparam int REG_AW = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/mul_div_iter.sv
// rtl/mul_div_iter.sv - one-bit-per-cycle shift-add multiplier / restoring divider
// The divide path exists only when EXEC_UNIT_DIV_EN is defined.
module mul_div_iter
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef EXEC_UNIT_DIV_EN
  input  logic              is_div,
`endif
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              upper_nz
);

  logic              busy;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] nxt_hi;
  logic [DATA_W-1:0] nxt_lo;
  logic [DATA_W:0]   sum;
`ifdef EXEC_UNIT_DIV_EN
  logic              div_q;
  logic [DATA_W:0]   r_sh;
`endif

  // hi/lo act as product {hi,lo} for MUL and as {remainder,quotient} for DIV
  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    nxt_hi = sum[DATA_W:1];
    nxt_lo = {sum[0], lo[DATA_W-1:1]};
`ifdef EXEC_UNIT_DIV_EN
    r_sh = {hi, lo[DATA_W-1]};
    if (div_q) begin
      if (r_sh >= {1'b0, opnd}) begin
        nxt_hi = DATA_W'(r_sh - {1'b0, opnd});
        nxt_lo = {lo[DATA_W-2:0], 1'b1};
      end else begin
        nxt_hi = r_sh[DATA_W-1:0];
        nxt_lo = {lo[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  assign done     = busy && (cnt == 5'(DATA_W - 1));
  assign result   = nxt_lo;
  assign upper_nz = |nxt_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      hi   <= '0;
      lo   <= '0;
      opnd <= '0;
`ifdef EXEC_UNIT_DIV_EN
      div_q <= 1'b0;
`endif
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      hi   <= '0;
      lo   <= a;
      opnd <= b;
`ifdef EXEC_UNIT_DIV_EN
      div_q <= is_div;
`endif
    end else if (busy) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute/writeback stage: single-cycle ALU, iterative MUL/DIV, flags
// EXEC_UNIT_DIV_EN enables DIV; without it DIV is an illegal opcode and div_err is 0.
module exec_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [REG_AW-1:0] rd,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  output logic              div_err,
  output logic              illegal_op
);

  state_t            state;
  logic [REG_AW-1:0] rd_q;
  logic              accept;
  logic              mul_start;
  logic              start;
  logic              it_done;
  logic              it_upper;
  logic [DATA_W-1:0] it_result;
  logic [DATA_W:0]   add_w;
  logic [DATA_W:0]   sub_w;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;

  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (opcode == OP_MUL);

`ifdef EXEC_UNIT_DIV_EN
  logic div_start;
  assign div_start = accept && (opcode == OP_DIV) && (read_data2 != '0);
  assign start     = mul_start || div_start;
`else
  assign start     = mul_start;
  assign div_err   = 1'b0;
`endif

  mul_div_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef EXEC_UNIT_DIV_EN
    .is_div   (div_start),
`endif
    .a        (read_data1),
    .b        (read_data2),
    .done     (it_done),
    .result   (it_result),
    .upper_nz (it_upper)
  );

  always_comb begin
    add_w   = {1'b0, read_data1} + {1'b0, read_data2};
    sub_w   = {1'b0, read_data1} - {1'b0, read_data2};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      OP_ADD: begin
        alu_res = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
        alu_v   = (read_data1[DATA_W-1] == read_data2[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != read_data1[DATA_W-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = (read_data1[DATA_W-1] != read_data2[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != read_data1[DATA_W-1]);
      end
      OP_AND: alu_res = read_data1 & read_data2;
      OP_OR:  alu_res = read_data1 | read_data2;
      OP_XOR: alu_res = read_data1 ^ read_data2;
      // shifting a 19-bit value by 19..31 already yields zero
      OP_SHL: alu_res = read_data1 << read_data2[4:0];
      OP_SHR: alu_res = read_data1 >> read_data2[4:0];
      OP_MOV: alu_res = read_data1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      rd_q       <= '0;
      write_reg  <= '0;
      write_data <= '0;
      reg_write  <= 1'b0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_v     <= 1'b0;
      illegal_op <= 1'b0;
`ifdef EXEC_UNIT_DIV_EN
      div_err    <= 1'b0;
`endif
    end else begin
      reg_write  <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (opcode)
              OP_NOP: ;
              OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MOV: begin
                reg_write  <= 1'b1;
                write_reg  <= rd;
                write_data <= alu_res;
                flag_z     <= (alu_res == '0);
                flag_c     <= alu_c;
                flag_v     <= alu_v;
              end
              OP_CMP: begin
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
                flag_v <= alu_v;
              end
              OP_MUL: begin
                state    <= ST_MUL;
                in_ready <= 1'b0;
                rd_q     <= rd;
              end
`ifdef EXEC_UNIT_DIV_EN
              OP_DIV: begin
                if (read_data2 == '0) begin
                  reg_write  <= 1'b1;
                  write_reg  <= rd;
                  write_data <= '1;
                  flag_z     <= 1'b0;
                  flag_c     <= 1'b0;
                  flag_v     <= 1'b0;
                  div_err    <= 1'b1;
                end else begin
                  state    <= ST_DIV;
                  in_ready <= 1'b0;
                  rd_q     <= rd;
                end
              end
`endif
              default: illegal_op <= 1'b1;
            endcase
          end
        end
        default: begin
          if (it_done) begin
            reg_write  <= 1'b1;
            write_reg  <= rd_q;
            write_data <= it_result;
            flag_z     <= (it_result == '0);
            flag_c     <= (state == ST_MUL) && it_upper;
            flag_v     <= 1'b0;
            state      <= ST_IDLE;
            in_ready   <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;

  localparam longint unsigned MOD = 524288;
  localparam logic [3:0] O_ADD = 4'd1, O_SUB = 4'd2, O_CMP = 4'd9, O_MUL = 4'd10, O_DIV = 4'd11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [3:0]  rd = '0;
  logic [18:0] read_data1 = '0;
  logic [18:0] read_data2 = '0;
  logic [3:0]  write_reg;
  logic [18:0] write_data;
  logic        reg_write, flag_z, flag_c, flag_v, div_err, illegal_op;
  logic [29:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  logic        m_z, m_c, m_v, m_err;
  logic [18:0] m_wd;
  logic [3:0]  m_wr;

  exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd),
    .read_data1(read_data1), .read_data2(read_data2), .write_reg(write_reg),
    .write_data(write_data), .reg_write(reg_write), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .div_err(div_err), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign obs = {reg_write, write_reg, write_data, flag_z, flag_c, flag_v, illegal_op, div_err, in_ready};

  function automatic longint sgn(input longint unsigned x);
    return (x >= 262144) ? longint'(x) - 524288 : longint'(x);
  endfunction

  task automatic model_reset();
    m_z = 0; m_c = 0; m_v = 0; m_err = 0; m_wd = '0; m_wr = '0;
  endtask

  // expected observation in the cycle the operation completes, plus its latency
  task automatic model_op(input logic [3:0] op, input logic [3:0] r, input logic [18:0] a_i,
                          input logic [18:0] b_i, output logic [29:0] exp, output int lat);
    longint unsigned a, b, res, amt;
    longint sr;
    logic c, v, wr, fl, ill;
    a = a_i; b = b_i; amt = b % 32; res = 0; sr = 0;
    c = 0; v = 0; wr = 0; fl = 0; ill = 0; lat = 1;
    case (op)
      0: ;
      1: begin res = (a + b) % MOD; c = (a + b) >= MOD; sr = sgn(a) + sgn(b); wr = 1; fl = 1; end
      2, 9: begin res = (a + MOD - b) % MOD; c = a < b; sr = sgn(a) - sgn(b); wr = (op == 2); fl = 1; end
      3: begin res = a & b; wr = 1; fl = 1; end
      4: begin res = a | b; wr = 1; fl = 1; end
      5: begin res = a ^ b; wr = 1; fl = 1; end
      6: begin res = (amt >= 19) ? 0 : (a << amt) % MOD; wr = 1; fl = 1; end
      7: begin res = (amt >= 19) ? 0 : a >> amt; wr = 1; fl = 1; end
      8: begin res = a; wr = 1; fl = 1; end
      10: begin res = (a * b) % MOD; c = (a * b) >= MOD; lat = 20; wr = 1; fl = 1; end
`ifdef EXEC_UNIT_DIV_EN
      11: begin
        if (b == 0) begin res = MOD - 1; m_err = 1; end
        else begin res = a / b; lat = 20; end
        wr = 1; fl = 1;
      end
`endif
      default: ill = 1;
    endcase
    if (op == 1 || op == 2 || op == 9) v = (sr > 262143) || (sr < -262144);
    if (fl) begin m_z = (res == 0); m_c = c; m_v = v; end
    if (wr) begin m_wd = 19'(res); m_wr = r; end
    exp = {wr, m_wr, m_wd, m_z, m_c, m_v, ill, m_err, 1'b1};
  endtask

  // issue one op; junk is driven on the inputs while the unit is busy
  task automatic run_op(input logic [3:0] op, input logic [3:0] r, input logic [18:0] a,
                        input logic [18:0] b, input int lat, output logic [29:0] o, output int bad);
    @(negedge clk);
    opcode = op; rd = r; read_data1 = a; read_data2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    bad = 0;
    for (int i = 1; i < lat; i++) begin
      if (in_ready !== 1'b0 || reg_write !== 1'b0) bad++;
      @(negedge clk);
      read_data1 = 19'($urandom); read_data2 = 19'($urandom);
      opcode = 4'($urandom); rd = 4'($urandom); in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    o = obs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== 30'h1) begin
      n_fail++; $display("FAIL reset_state: got %h exp %h", obs, 30'h1);
    end
    @(negedge clk); rst = 1'b0;
    model_reset();
  endtask

  task automatic test_add();
    logic [29:0] exp, o; int lat, bad;
    model_op(O_ADD, 4'd1, 19'd25, 19'd50, exp, lat);
    run_op(O_ADD, 4'd1, 19'd25, 19'd50, lat, o, bad);
    n_checks++;
    if (o !== exp) begin n_fail++; $display("FAIL add_model: got %h exp %h", o, exp); end
    n_checks++;
    if (reg_write !== 1'b1 || write_reg !== 4'd1 || write_data !== 19'd75 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      n_fail++; $display("FAIL add_25_50: got we=%b wr=%0d wd=%0d z=%b c=%b exp we=1 wr=1 wd=75 z=0 c=0",
                         reg_write, write_reg, write_data, flag_z, flag_c);
    end
  endtask

  task automatic test_sub_cmp();
    logic [29:0] exp, o; int lat, bad;
    model_op(O_SUB, 4'd2, 19'd25, 19'd50, exp, lat);
    run_op(O_SUB, 4'd2, 19'd25, 19'd50, lat, o, bad);
    n_checks++;
    if (o !== exp) begin n_fail++; $display("FAIL sub_model: got %h exp %h", o, exp); end
    n_checks++;
    if (write_data !== 19'h7FFE7 || flag_c !== 1'b1 || flag_v !== 1'b0) begin
      n_fail++; $display("FAIL sub_25_50: got wd=%h c=%b v=%b exp wd=7ffe7 c=1 v=0", write_data, flag_c, flag_v);
    end
    model_op(O_CMP, 4'd5, 19'd50, 19'd50, exp, lat);
    run_op(O_CMP, 4'd5, 19'd50, 19'd50, lat, o, bad);
    n_checks++;
    if (o !== exp || flag_z !== 1'b1 || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL cmp_equal: got %h exp %h", o, exp);
    end
  endtask

  task automatic test_mul_back_to_back();
    logic [29:0] exp, o; int lat, bad;
    model_op(O_MUL, 4'd3, 19'd1000, 19'd1000, exp, lat);
    run_op(O_MUL, 4'd3, 19'd1000, 19'd1000, lat, o, bad);
    n_checks++;
    if (bad != 0 || lat != 20) begin n_fail++; $display("FAIL mul_busy: got %0d busy-cycle violations exp 0", bad); end
    n_checks++;
    if (o !== exp || write_data !== 19'd475712 || flag_c !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mul_1000x1000: got %h wd=%0d exp %h wd=475712", o, write_data, exp);
    end
    model_op(O_ADD, 4'd7, 19'd3, 19'd4, exp, lat);
    run_op(O_ADD, 4'd7, 19'd3, 19'd4, lat, o, bad);
    n_checks++;
    if (o !== exp) begin n_fail++; $display("FAIL add_after_mul: got %h exp %h", o, exp); end
    for (int i = 0; i < 3; i++) begin
      model_op(O_ADD, 4'(i), 19'(i * 100), 19'd1, exp, lat);
      run_op(O_ADD, 4'(i), 19'(i * 100), 19'd1, lat, o, bad);
      n_checks++;
      if (o !== exp) begin n_fail++; $display("FAIL back_to_back_%0d: got %h exp %h", i, o, exp); end
    end
  endtask

  task automatic test_div();
    logic [29:0] exp, o; int lat, bad;
`ifdef EXEC_UNIT_DIV_EN
    model_op(O_DIV, 4'd4, 19'd50, 19'd7, exp, lat);
    run_op(O_DIV, 4'd4, 19'd50, 19'd7, lat, o, bad);
    n_checks++;
    if (o !== exp || bad != 0 || write_data !== 19'd7) begin
      n_fail++; $display("FAIL div_50_7: got %h wd=%0d busy_bad=%0d exp %h wd=7", o, write_data, bad, exp);
    end
    model_op(O_DIV, 4'd6, 19'd50, 19'd0, exp, lat);
    run_op(O_DIV, 4'd6, 19'd50, 19'd0, lat, o, bad);
    n_checks++;
    if (o !== exp || write_data !== 19'h7FFFF || div_err !== 1'b1 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL div_by_zero: got %h exp %h", o, exp);
    end
`else
    model_op(O_DIV, 4'd4, 19'd50, 19'd7, exp, lat);
    run_op(O_DIV, 4'd4, 19'd50, 19'd7, lat, o, bad);
    n_checks++;
    if (o !== exp || illegal_op !== 1'b1 || reg_write !== 1'b0 || div_err !== 1'b0) begin
      n_fail++; $display("FAIL div_disabled: got %h exp %h", o, exp);
    end
`endif
  endtask

  task automatic test_illegal();
    logic [29:0] exp, o; int lat, bad;
    for (int op = 12; op < 16; op++) begin
      model_op(4'(op), 4'd9, 19'd11, 19'd22, exp, lat);
      run_op(4'(op), 4'd9, 19'd11, 19'd22, lat, o, bad);
      n_checks++;
      if (o !== exp || illegal_op !== 1'b1 || reg_write !== 1'b0) begin
        n_fail++; $display("FAIL illegal_op_%0d: got %h exp %h", op, o, exp);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int wrote;
    @(negedge clk);
    opcode = O_MUL; rd = 4'd3; read_data1 = 19'd1000; read_data2 = 19'd1000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    wrote = (reg_write === 1'b1) ? 1 : 0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    n_checks++;
    if (in_ready !== 1'b1 || flag_z !== 1'b0 || flag_c !== 1'b0 || flag_v !== 1'b0 || reg_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_mul_state: got %h exp %h", obs, 30'h1);
    end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (reg_write !== 1'b0) wrote++;
    end
    n_checks++;
    if (wrote != 0) begin n_fail++; $display("FAIL reset_mid_mul_write: got %0d writes exp 0", wrote); end
  endtask

  task automatic test_random();
    logic [29:0] exp, o; int lat, bad;
    logic [3:0] op, r; logic [18:0] a, b;
    logic [18:0] ext[4];
    ext[0] = 19'h0; ext[1] = 19'h7FFFF; ext[2] = 19'h40000; ext[3] = 19'h3FFFF;
    for (int n = 0; n < 150; n++) begin
      op = 4'($urandom_range(0, 15)); r = 4'($urandom);
      case ($urandom_range(0, 3))
        0: begin a = 19'($urandom); b = 19'($urandom); end
        1: begin a = 19'($urandom_range(0, 40)); b = 19'($urandom_range(0, 40)); end
        2: begin a = ext[$urandom_range(0, 3)]; b = ext[$urandom_range(0, 3)]; end
        default: begin a = 19'($urandom); b = a; end
      endcase
      model_op(op, r, a, b, exp, lat);
      run_op(op, r, a, b, lat, o, bad);
      n_checks++;
      if (o !== exp || bad != 0) begin
        n_fail++; $display("FAIL random_%0d op=%0d a=%h b=%h: got %h busy_bad=%0d exp %h", n, op, a, b, o, bad, exp);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_sub_cmp();
    test_mul_back_to_back();
    test_div();
    test_illegal();
    test_reset_mid_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
